// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift sequencer.
//   shift_state_t : sequencer FSM encoding
//   sat_amount()  : clamps a requested step count to the data width
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // Shifting an (n+1)-bit word by more than n+1 steps gives the same
    // result as shifting by exactly n+1, so the count is clamped there.
    function automatic int unsigned sat_amount(input int unsigned amount,
                                               input int unsigned n);
        return (amount > n + 1) ? n + 1 : amount;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit logical right shift with an explicit fill bit. Purely combinational.
// Ports:
//   din  [N:0]  word to shift
//   fill        bit placed into the MSB
//   dout [N:0]  {fill, din[N:1]}
module shift_step #(
    parameter int N = 7
) (
    input  logic [N:0] din,
    input  logic       fill,
    output logic [N:0] dout
);

    assign dout = {fill, din[N:1]};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step logical/arithmetic right shifter built from a single one-bit
// shift stage, applied once per clock. Start/done handshake.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start             request, only sampled in IDLE
//   din, amount,arith operands, captured with start
//   busy              high while SHIFT or DONE
//   done              one-cycle pulse when dout is valid
//   dout              result, held until the next completion
//   sout              bit shifted out by the most recent step
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for start
// SHIFT | one shift step per cycle, counter decrements
// DONE  | done pulse, dout valid, back to IDLE next
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N  = 7,
    parameter int AW = $clog2(N + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N:0]    din,
    input  logic [AW-1:0] amount,
    input  logic          arith,
    output logic          busy,
    output logic          done,
    output logic [N:0]    dout,
    output logic          sout
);

    shift_state_t  state, state_next;
    logic [N:0]    work, work_next;
    logic [AW-1:0] cnt, cnt_next;
    logic          fill, fill_next;
    logic          sout_next;
    logic [N:0]    dout_next;
    logic [N:0]    step_out;
    logic [AW-1:0] amt_sat;

    assign amt_sat = AW'(sat_amount(32'(amount), N));

    shift_step #(.N(N)) u_step (
        .din  (work),
        .fill (fill),
        .dout (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            fill  <= 1'b0;
            sout  <= 1'b0;
            dout  <= '0;
        end else begin
            state <= state_next;
            work  <= work_next;
            cnt   <= cnt_next;
            fill  <= fill_next;
            sout  <= sout_next;
            dout  <= dout_next;
        end
    end

    always_comb begin
        state_next = state;
        work_next  = work;
        cnt_next   = cnt;
        fill_next  = fill;
        sout_next  = sout;
        dout_next  = dout;

        case (state)
            IDLE: begin
                if (start) begin
                    work_next = din;
                    cnt_next  = amt_sat;
                    // Only the fill value matters later, so arith and the
                    // sign bit are folded together at capture time.
                    fill_next = arith & din[N];
                    state_next = (amt_sat == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_next = step_out;
                sout_next = work[0];
                cnt_next  = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // dout loads on the edge that enters DONE so it is valid together
        // with the done pulse, including the zero-step path from IDLE.
        if (state_next == DONE && state != DONE) begin
            dout_next = work_next;
        end
    end

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (N = 7).
module tb_shift_sequencer;

    localparam int N  = 7;
    localparam int AW = $clog2(N + 2);

    logic          clk;
    logic          reset;
    logic          start;
    logic [N:0]    din;
    logic [AW-1:0] amount;
    logic          arith;
    logic          busy;
    logic          done;
    logic [N:0]    dout;
    logic          sout;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.N(N), .AW(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .din    (din),
        .amount (amount),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .sout   (sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and follows it to completion. Called while in
    // IDLE, #1 after a rising edge. Returns #1 after the edge that follows
    // the done cycle, i.e. back in IDLE. exp_cyc is the cycle index (T0+n)
    // in which done must be high. sout is recorded after every edge from
    // T0+1 on; bit j of seq is the value seen in cycle T0+2+j.
    task automatic run_op(input string tag, input logic [N:0] d,
                          input logic [AW-1:0] amt, input logic ar,
                          input logic [N:0] exp_dout, input int exp_cyc,
                          input bit inject, output logic [31:0] seq);
        int cyc;
        seq    = '0;
        start  = 1'b1;
        din    = d;
        amount = amt;
        arith  = ar;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~d;
        arith = ~ar;
        cyc   = 1;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        while (!done && cyc < 30) begin
            if (inject && cyc == 2) begin
                start  = 1'b1;
                din    = 8'hFF;
                amount = AW'(1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= 2) seq[cyc-2] = sout;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_dout_hold"}, 32'(dout), 32'(exp_dout));
    endtask

    // Watches n cycles and returns how many had done high.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq;
        int          ndone;

        reset  = 1'b1;
        start  = 1'b0;
        din    = '0;
        amount = '0;
        arith  = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_sout", 32'(sout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1011_0100 >> 3 logical: 0001_0110, bits out 0,0,1
        run_op("lsr3", 8'hB4, 4'd3, 1'b0, 8'h16, 4, 1'b0, seq);
        check("lsr3_sout_seq", {29'd0, seq[2:0]}, 32'b100);

        run_op("asr3", 8'hB4, 4'd3, 1'b1, 8'hF6, 4, 1'b0, seq);
        check("asr3_sout_seq", {29'd0, seq[2:0]}, 32'b100);

        run_op("zero", 8'h5A, 4'd0, 1'b0, 8'h5A, 1, 1'b0, seq);
        run_op("sat15", 8'h80, 4'd15, 1'b1, 8'hFF, 9, 1'b0, seq);
        run_op("full8", 8'hFF, 4'd8, 1'b0, 8'h00, 9, 1'b0, seq);
        run_op("sat9", 8'hFF, 4'd9, 1'b0, 8'h00, 9, 1'b0, seq);
        run_op("asr1", 8'h41, 4'd1, 1'b1, 8'h20, 2, 1'b0, seq);
        check("asr1_sout", 32'(seq[0]), 32'd1);

        // start pulsed mid-SHIFT with other operands must be ignored
        run_op("inject", 8'h3C, 4'd4, 1'b0, 8'h03, 5, 1'b1, seq);
        count_done(4, ndone);
        check("inject_no_extra_done", 32'(ndone), 32'd0);

        // back-to-back: second start is driven in the IDLE cycle after done
        run_op("b2b_a", 8'h81, 4'd1, 1'b1, 8'hC0, 2, 1'b0, seq);
        run_op("b2b_b", 8'h81, 4'd2, 1'b0, 8'h20, 3, 1'b0, seq);

        // reset three steps into a six-step op
        start  = 1'b1;
        din    = 8'hF0;
        amount = 4'd6;
        arith  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_sout", 32'(sout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(10, ndone);
        check("mid_rst_no_done", 32'(ndone), 32'd0);

        run_op("recover", 8'h0F, 4'd2, 1'b0, 8'h03, 3, 1'b0, seq);
        check("recover_sout_seq", {30'd0, seq[1:0]}, 32'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
